// File: rtl/bk_add_pkg.sv
// Shared types and helpers for the Brent-Kung adder pipeline stage.
// Holds the nominal adder width, operand/result record types and the
// operand-to-adder-bus interleave function.
package bk_add_pkg;

    localparam int BK_W     = 12;
    localparam int BK_TAG_W = 4;

    typedef struct packed {
        logic [BK_W-1:0]     a;
        logic [BK_W-1:0]     b;
        logic [BK_TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [BK_W:0]       sum;
        logic [BK_TAG_W-1:0] tag;
    } res_t;

    // The adder expects operand bits paired per position: even = a, odd = b.
    function automatic logic [2*BK_W-1:0] interleave(input logic [BK_W-1:0] a,
                                                     input logic [BK_W-1:0] b);
        logic [2*BK_W-1:0] bus;
        bus = '0;
        for (int i = 0; i < BK_W; i++) begin
            bus[2*i]   = a[i];
            bus[2*i+1] = b[i];
        end
        return bus;
    endfunction

endpackage

// File: rtl/bk_add_pipe_stage_slice.sv
// bk_pipe_slice: one-entry valid/ready register slice.
// Accepts a new word in the same cycle the held word is popped, so a chain
// of slices sustains one transfer per clock with no bubbles.
module bk_pipe_slice
#(
    parameter int DW = 8
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          load_s;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign load_s      = in_valid_i && in_ready_o;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next state: load on accept, empty on pop without refill, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_s) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slice state register; reset clears both flag and payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/bk_add_pipe_stage.sv
// bk_add_pipe_stage: two-register pipeline around an external combinational
// Brent-Kung adder. S1 holds operands and drives the interleaved adder bus,
// S2 captures the sum with its tag. A saturating counter tracks carry-outs.
// Optional build macro BK_ADD_PIPE_CHECK_EN adds chk_err, a sticky flag set
// when the adder result disagrees with a behavioural sum of the S1 operands.
module bk_add_pipe_stage
    import bk_add_pkg::*;
#(
    parameter int W     = BK_W,
    parameter int TAG_W = BK_TAG_W,
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_a,
    input  logic [W-1:0]     s_b,
    input  logic [TAG_W-1:0] s_tag,
    output logic [2*W-1:0]   add_in,
    input  logic [W:0]       add_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W:0]       m_sum,
    output logic [TAG_W-1:0] m_tag,
    output logic [CNT_W-1:0] cout_cnt
`ifdef BK_ADD_PIPE_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    localparam int OP_W  = 2*W + TAG_W;
    localparam int RES_W = W + 1 + TAG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [OP_W-1:0]  s1_in_s;
    logic [OP_W-1:0]  s1_data_s;
    logic             s1_valid_s;
    logic             s2_ready_s;
    logic [W-1:0]     s1_a_s;
    logic [W-1:0]     s1_b_s;
    logic [TAG_W-1:0] s1_tag_s;
    logic [RES_W-1:0] s2_in_s;
    logic [RES_W-1:0] s2_data_s;
    logic             s2_load_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign s1_in_s = {s_a, s_b, s_tag};

    bk_pipe_slice #(.DW(OP_W)) u_s1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s_valid),
        .in_ready_o  (s_ready),
        .in_data_i   (s1_in_s),
        .out_valid_o (s1_valid_s),
        .out_ready_i (s2_ready_s),
        .out_data_o  (s1_data_s)
    );

    assign {s1_a_s, s1_b_s, s1_tag_s} = s1_data_s;

    // Adder bus comes only from S1 flops, so it is glitch-free and zero in reset.
    if (W == BK_W) begin : g_pkg_ilv
        assign add_in = interleave(s1_a_s, s1_b_s);
    end else begin : g_loop_ilv
        for (genvar i = 0; i < W; i++) begin : g_bit
            assign add_in[2*i]   = s1_a_s[i];
            assign add_in[2*i+1] = s1_b_s[i];
        end
    end

    assign s2_in_s = {add_out, s1_tag_s};

    bk_pipe_slice #(.DW(RES_W)) u_s2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid_s),
        .in_ready_o  (s2_ready_s),
        .in_data_i   (s2_in_s),
        .out_valid_o (m_valid),
        .out_ready_i (m_ready),
        .out_data_o  (s2_data_s)
    );

    assign {m_sum, m_tag} = s2_data_s;
    assign s2_load_s      = s1_valid_s && s2_ready_s;
    assign cout_cnt       = cnt_q;

    // Count results captured with carry-out set; hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_load_s && add_out[W] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Carry-out counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef BK_ADD_PIPE_CHECK_EN
    logic [W:0] ref_sum_s;
    logic       chk_err_q;
    logic       chk_err_d;

    assign ref_sum_s = {1'b0, s1_a_s} + {1'b0, s1_b_s};
    assign chk_err   = chk_err_q;

    // Sticky error: set on any S2 load where the adder disagrees with the reference.
    always_comb begin
        chk_err_d = chk_err_q;
        if (s2_load_s && (add_out != ref_sum_s)) begin
            chk_err_d = 1'b1;
        end else begin
            chk_err_d = chk_err_q;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_bk_add_pipe_stage.sv
// Directed bench for bk_add_pipe_stage. A behavioural adder closes the loop
// from add_in to add_out; a second instance with CNT_W=2 shows saturation.
module tb_bk_add_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic        s_ready2;
    logic [11:0] s_a;
    logic [11:0] s_b;
    logic [3:0]  s_tag;
    logic [23:0] add_in;
    logic [23:0] add_in2;
    logic [12:0] add_out;
    logic [12:0] add_out2;
    logic        m_valid;
    logic        m_valid2;
    logic        m_ready;
    logic [12:0] m_sum;
    logic [12:0] m_sum2;
    logic [3:0]  m_tag;
    logic [3:0]  m_tag2;
    logic [15:0] cout_cnt;
    logic [1:0]  cout_cnt2;
    logic        corrupt;
`ifdef BK_ADD_PIPE_CHECK_EN
    logic        chk_err;
    logic        chk_err2;
`endif

    always #5 clk = ~clk;

    function automatic logic [12:0] bench_add(input logic [23:0] bus);
        logic [11:0] a;
        logic [11:0] b;
        for (int i = 0; i < 12; i++) begin
            a[i] = bus[2*i];
            b[i] = bus[2*i+1];
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign add_out  = bench_add(add_in) ^ {12'h000, corrupt};
    assign add_out2 = bench_add(add_in2);

    bk_add_pipe_stage dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_tag(s_tag), .add_in(add_in), .add_out(add_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_tag(m_tag),
        .cout_cnt(cout_cnt)
`ifdef BK_ADD_PIPE_CHECK_EN
        , .chk_err(chk_err)
`endif
    );

    bk_add_pipe_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2),
        .s_a(s_a), .s_b(s_b), .s_tag(s_tag), .add_in(add_in2), .add_out(add_out2),
        .m_valid(m_valid2), .m_ready(m_ready), .m_sum(m_sum2), .m_tag(m_tag2),
        .cout_cnt(cout_cnt2)
`ifdef BK_ADD_PIPE_CHECK_EN
        , .chk_err(chk_err2)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected {tag, sum} pushed on accept, compared on delivery.
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int          n_pop = 0;
    logic [15:0] exp_cnt  = 16'h0000;
    logic [1:0]  exp_cnt2 = 2'd0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt  = 16'h0000;
            exp_cnt2 = 2'd0;
        end else begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_sum", {19'd0, m_sum}, {19'd0, e[12:0]});
                    check("res_tag", {28'd0, m_tag}, {28'd0, e[16:13]});
                    n_pop++;
                    if (e[12]) begin
                        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                        if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
                    end
                end
            end
            if (s_valid && s_ready) begin
                exp_q.push_back({s_tag, ({1'b0, s_a} + {1'b0, s_b}) ^ {12'h000, corrupt}});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [11:0] a, input logic [11:0] b, input logic [3:0] t);
        bit fire;
        int n;
        s_a = a; s_b = b; s_tag = t; s_valid = 1'b1;
        fire = 1'b0;
        n = 0;
        while (!fire && n < 50) begin
            @(negedge clk);
            fire = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accepted", {31'd0, fire}, 32'd1);
        s_valid = 1'b0;
    endtask

    logic [11:0] bp_a [3];
    logic [11:0] bp_b [3];
    int stall;
    int acc;
    int pops_before;
    int stale;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_a = 12'h000; s_b = 12'h000; s_tag = 4'h0;
        m_ready = 1'b1; corrupt = 1'b0;
        repeat (3) step();
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_sum", {19'd0, m_sum}, 32'd0);
        check("rst_m_tag", {28'd0, m_tag}, 32'd0);
        check("rst_add_in", {8'd0, add_in}, 32'd0);
        check("rst_cout", {16'd0, cout_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check("s_ready_after_rst", {31'd0, s_ready}, 32'd1);
        check("s_ready2_after_rst", {31'd0, s_ready2}, 32'd1);

        // 1 + 1: operands land in S1 after one edge, result after the next.
        s_a = 12'h001; s_b = 12'h001; s_tag = 4'd3; s_valid = 1'b1;
        step();
        check("add_in_1p1", {8'd0, add_in}, 32'h000003);
        check("m_valid_early", {31'd0, m_valid}, 32'd0);
        s_valid = 1'b0;
        step();
        check("m_valid_1p1", {31'd0, m_valid}, 32'd1);
        check("m_sum_1p1", {19'd0, m_sum}, 32'h0002);
        check("m_tag_1p1", {28'd0, m_tag}, 32'd3);
        check("cout_1p1", {16'd0, cout_cnt}, 32'd0);
        step(); step();

        send_one(12'hFFF, 12'h001, 4'd5);
        step();
        check("m_sum_fff_1", {19'd0, m_sum}, 32'h1000);
        check("m_tag_fff_1", {28'd0, m_tag}, 32'd5);
        step();
        check("cout_after_1", {16'd0, cout_cnt}, 32'd1);

        send_one(12'hFFF, 12'hFFF, 4'd6);
        step();
        check("m_sum_fff_fff", {19'd0, m_sum}, 32'h1FFE);
        step();
        check("cout_after_2", {16'd0, cout_cnt}, 32'd2);
        check("cout2_after_2", {30'd0, cout_cnt2}, 32'd2);

        // Five more carry-outs: the 2-bit counter must stop at 3.
        for (int i = 0; i < 5; i++) send_one(12'h800, 12'h800, i[3:0]);
        step();
        check("m_valid2_last", {31'd0, m_valid2}, 32'd1);
        check("m_sum2_last", {19'd0, m_sum2}, 32'h1000);
        check("m_tag2_last", {28'd0, m_tag2}, 32'd4);
        repeat (3) step();
        check("cout_after_7", {16'd0, cout_cnt}, 32'd7);
        check("cout2_saturated", {30'd0, cout_cnt2}, 32'd3);

        // 100 back-to-back random ops with no backpressure.
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            s_a = 12'($urandom); s_b = 12'($urandom); s_tag = 4'($urandom);
            s_valid = 1'b1;
            @(negedge clk);
            if (!s_ready) stall++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        repeat (4) step();
        check("stream_stalls", stall, 32'd0);
        check("stream_drained", exp_q.size(), 32'd0);
        check("stream_pops", n_pop, 32'd108);
        check("stream_cout", {16'd0, cout_cnt}, {16'd0, exp_cnt});
        check("stream_cout2", {30'd0, cout_cnt2}, {30'd0, exp_cnt2});

        // Backpressure: 3 ops offered over 5 stalled cycles.
        bp_a[0] = 12'h123; bp_b[0] = 12'h456;
        bp_a[1] = 12'h800; bp_b[1] = 12'h800;
        bp_a[2] = 12'h0AA; bp_b[2] = 12'h055;
        m_ready = 1'b0;
        pops_before = n_pop;
        acc = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            s_a = bp_a[acc]; s_b = bp_b[acc]; s_tag = 4'(7 + acc);
            s_valid = 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) acc++;
            @(posedge clk);
            #1;
            if (cyc >= 1) check("bp_m_sum_hold", {19'd0, m_sum}, 32'h0579);
        end
        check("bp_accepted", acc, 32'd2);
        check("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
        check("bp_m_valid", {31'd0, m_valid}, 32'd1);
        check("bp_m_tag", {28'd0, m_tag}, 32'd7);
        m_ready = 1'b1;
        send_one(12'h0AA, 12'h055, 4'd9);
        repeat (4) step();
        check("bp_delivered", n_pop - pops_before, 32'd3);
        check("bp_drained", exp_q.size(), 32'd0);

        // Reset with both stages full.
        m_ready = 1'b0;
        send_one(12'h001, 12'h002, 4'd1);
        send_one(12'h003, 12'h004, 4'd2);
        check("pre_rst_full", {31'd0, m_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_async_add_in", {8'd0, add_in}, 32'd0);
        check("rst_async_cout", {16'd0, cout_cnt}, 32'd0);
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid) stale++;
        end
        check("no_stale_result", stale, 32'd0);
        check("s_ready_post_rst", {31'd0, s_ready}, 32'd1);

`ifdef BK_ADD_PIPE_CHECK_EN
        step();
        check("chk_err_clean", {31'd0, chk_err}, 32'd0);
        corrupt = 1'b1;
        send_one(12'h010, 12'h020, 4'd4);
        step();
        corrupt = 1'b0;
        check("chk_err_set", {31'd0, chk_err}, 32'd1);
        repeat (5) step();
        check("chk_err_sticky", {31'd0, chk_err}, 32'd1);
        check("chk_err2_clean", {31'd0, chk_err2}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        check("watchdog", 32'd0, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
